// File: rtl/stage_mem_lsu.sv
// stage_mem_lsu -- MEM pipeline stage with a variable-latency load path.
//
// Sits between EX and WB using the valid/allowin handshake. A load enters
// with its SRAM request already accepted by EX. The stage stalls in WAIT
// until data_ok arrives. It buffers the response in rbuf so that WB
// backpressure never loses data. Then it extracts the addressed byte, half,
// word or dword with sign or zero extension. A flush kills the held
// instruction. If its response is still in flight, the stage sits in DISCARD
// and swallows that response before it accepts anything new.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   allowout / validin        handshake from WB / from EX
//   allowin / validout        handshake to EX / to WB
//   flush                     cancel the in-stage instruction
//   input_pc, input_rf_*      instruction fields latched on refresh
//   input_mem_*               load control: read, size (0..3), unsigned
//   input_alu_result          load address or non-load result
//   data_sram_data_ok/rdata   read response channel
//   output_pc, output_rf_*    held fields and write-back data
//   output_fwd_valid          write-back data is final (safe to forward)

module stage_mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int RF_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  allowout,
  input  logic                  validin,
  output logic                  allowin,
  output logic                  validout,
  input  logic                  flush,
  input  logic [31:0]           input_pc,
  output logic [31:0]           output_pc,
  input  logic [RF_ADDR_W-1:0]  input_rf_waddr,
  input  logic                  input_rf_we,
  output logic [RF_ADDR_W-1:0]  output_rf_waddr,
  output logic                  output_rf_we,
  input  logic                  input_mem_read,
  input  logic [1:0]            input_mem_size,
  input  logic                  input_mem_unsigned,
  input  logic [DATA_WIDTH-1:0] input_alu_result,
  input  logic                  data_sram_data_ok,
  input  logic [DATA_WIDTH-1:0] data_sram_rdata,
  output logic [DATA_WIDTH-1:0] output_rf_wdata,
  output logic                  output_fwd_valid
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no load outstanding
    WAIT    = 2'd1,  // load held, response not yet seen
    DONE    = 2'd2,  // response captured in rbuf
    DISCARD = 2'd3   // flushed load, its response still in flight
  } state_t;

  state_t                state, state_next;
  logic                  valid;
  logic [31:0]           pc;
  logic [RF_ADDR_W-1:0]  rf_waddr;
  logic                  rf_we;
  logic                  mem_read;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] rbuf;

  logic readygo;
  logic refresh;
  logic pop;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign readygo  = !(valid && mem_read && (state != DONE));
  // DISCARD holds EX off until the orphaned response has been absorbed.
  // Otherwise that response could be taken as the next load's data.
  // During a flush the stage reports allowin=1 because EX is flushed too.
  assign allowin  = (state != DISCARD) && (flush || !valid || (readygo && allowout));
  assign validout = valid && readygo && !flush;
  // A refresh on a flush edge would capture an instruction EX is killing.
  assign refresh  = validin && allowin && !flush;
  assign pop      = validout && allowout;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default on
  // entry. Without it, a path that skips the assignment infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (flush)        state_next = IDLE;
        else if (refresh) state_next = input_mem_read ? WAIT : IDLE;
        else if (pop)     state_next = IDLE;
      end
      WAIT: begin
        // If the response and the flush land together, the response is
        // consumed now, so nothing is left to discard.
        if (data_sram_data_ok) state_next = flush ? IDLE : DONE;
        else if (flush)        state_next = DISCARD;
      end
      DISCARD: begin
        if (data_sram_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      if (flush)        valid <= 1'b0;
      else if (allowin) valid <= validin;
    end
  end

  // ---------------------------------------------------------------------------
  // Held instruction fields and response buffer
  // ---------------------------------------------------------------------------
  // NOTE: these are plain flops, not a RAM, so they take the reset. That makes
  // every output read zero immediately after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= '0;
      rf_waddr     <= '0;
      rf_we        <= 1'b0;
      mem_read     <= 1'b0;
      mem_size     <= 2'd0;
      mem_unsigned <= 1'b0;
      alu_result   <= '0;
      rbuf         <= '0;
    end else begin
      if (refresh) begin
        pc           <= input_pc;
        rf_waddr     <= input_rf_waddr;
        rf_we        <= input_rf_we;
        mem_read     <= input_mem_read;
        mem_size     <= input_mem_size;
        mem_unsigned <= input_mem_unsigned;
        alu_result   <= input_alu_result;
      end
      // The SRAM may change rdata after data_ok, so the response is captured
      // here and WB reads the buffer rather than the bus.
      if ((state == WAIT) && data_sram_data_ok && !flush) begin
        rbuf <= data_sram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sub-word extraction
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]      off_mask;
  logic [OFF_W-1:0]      off;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] extracted;

  always_comb begin
    // Low address bits below the access size are ignored. Alignment has
    // already been checked upstream, so this only keeps the shift in range.
    off_mask = OFF_W'((32'd1 << mem_size) - 32'd1);
    off      = alu_result[OFF_W-1:0] & ~off_mask;
    shifted  = rbuf >> {off, 3'b000};

    keep_mask = '1;
    sign_bit  = shifted[DATA_WIDTH-1];
    unique case (mem_size)
      2'd0: begin
        keep_mask = DATA_WIDTH'(8'hFF);
        sign_bit  = shifted[7];
      end
      2'd1: begin
        keep_mask = DATA_WIDTH'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      2'd2: begin
        keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = shifted[DATA_WIDTH-1];
      end
    endcase

    // A full-width access has an all-ones keep mask, so the fill term is zero.
    extracted = (shifted & keep_mask)
              | ({DATA_WIDTH{sign_bit && !mem_unsigned}} & ~keep_mask);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign output_pc        = pc;
  assign output_rf_waddr  = rf_waddr;
  assign output_rf_we     = valid && rf_we;
  assign output_rf_wdata  = mem_read ? extracted : alu_result;
  assign output_fwd_valid = valid && rf_we && readygo;

  // Responses belong only to an outstanding or discarded load. An empty stage
  // tolerates a stray response, because that can only be a pre-reset orphan.
  a_data_ok_owner : assert property (@(posedge clk) disable iff (!rst)
    data_sram_data_ok |-> ((state == WAIT) || (state == DISCARD) || !valid));

endmodule

// File: tb/tb_stage_mem_lsu.sv
module tb_stage_mem_lsu;

  logic        clk;
  logic        rst;
  logic        allowout;
  logic        validin;
  logic        flush;
  logic [31:0] input_pc;
  logic [4:0]  input_rf_waddr;
  logic        input_rf_we;
  logic        input_mem_read;
  logic [1:0]  input_mem_size;
  logic        input_mem_unsigned;
  logic [31:0] alu32;
  logic [63:0] alu64;
  logic        data_ok;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  logic        allowin,  validout,  rf_we,  fwd_valid;
  logic [31:0] out_pc;
  logic [4:0]  rf_waddr;
  logic [31:0] wdata32;
  logic        allowin64, validout64, rf_we64, fwd_valid64;
  logic [31:0] out_pc64;
  logic [4:0]  rf_waddr64;
  logic [63:0] wdata64;

  int checks   = 0;
  int failures = 0;

  stage_mem_lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .allowout(allowout), .validin(validin),
    .allowin(allowin), .validout(validout), .flush(flush),
    .input_pc(input_pc), .output_pc(out_pc),
    .input_rf_waddr(input_rf_waddr), .input_rf_we(input_rf_we),
    .output_rf_waddr(rf_waddr), .output_rf_we(rf_we),
    .input_mem_read(input_mem_read), .input_mem_size(input_mem_size),
    .input_mem_unsigned(input_mem_unsigned), .input_alu_result(alu32),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata32),
    .output_rf_wdata(wdata32), .output_fwd_valid(fwd_valid)
  );

  stage_mem_lsu #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .allowout(allowout), .validin(validin),
    .allowin(allowin64), .validout(validout64), .flush(flush),
    .input_pc(input_pc), .output_pc(out_pc64),
    .input_rf_waddr(input_rf_waddr), .input_rf_we(input_rf_we),
    .output_rf_waddr(rf_waddr64), .output_rf_we(rf_we64),
    .input_mem_read(input_mem_read), .input_mem_size(input_mem_size),
    .input_mem_unsigned(input_mem_unsigned), .input_alu_result(alu64),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64),
    .output_rf_wdata(wdata64), .output_fwd_valid(fwd_valid64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic ld, input logic [1:0] size, input logic uns,
                       input logic [63:0] val, input logic [31:0] pc,
                       input logic we, input logic [4:0] waddr);
    validin            = 1'b1;
    input_mem_read     = ld;
    input_mem_size     = size;
    input_mem_unsigned = uns;
    alu64              = val;
    alu32              = val[31:0];
    input_pc           = pc;
    input_rf_we        = we;
    input_rf_waddr     = waddr;
  endtask

  task automatic respond(input logic [63:0] rd);
    data_ok = 1'b1;
    rdata64 = rd;
    rdata32 = rd[31:0];
  endtask

  task automatic scramble_bus();
    data_ok = 1'b0;
    rdata32 = $urandom;
    rdata64 = {$urandom, $urandom};
  endtask

  // One load through the stage with allowout held high. It returns what each
  // instance writes back.
  task automatic run_load(input logic [1:0] size, input logic uns, input logic [63:0] addr,
                          input logic [63:0] rd, input int lat,
                          output logic [63:0] got32, output logic [63:0] got64);
    int n;
    offer(1'b1, size, uns, addr, 32'h0000_2000, 1'b1, 5'd3);
    n = 0;
    @(negedge clk);
    while (!allowin && n < 20) begin cyc(); @(negedge clk); n++; end
    check("ld_accept", allowin, 1);
    cyc();
    validin = 1'b0;
    repeat (lat) cyc();
    respond(rd);
    cyc();
    scramble_bus();
    n = 0;
    @(negedge clk);
    while (!validout && n < 20) begin cyc(); @(negedge clk); n++; end
    check("ld_complete", validout, 1);
    got32 = 64'(wdata32);
    got64 = wdata64;
    cyc();
  endtask

  // Reference extraction, stated as arithmetic on the addressed field.
  function automatic logic [31:0] ref_load(input int size, input bit uns,
                                           input logic [31:0] addr, input logic [31:0] rd);
    longint unsigned nbytes, nbits, off, field, full;
    nbytes = 64'd1 << size;
    nbits  = 8 * nbytes;
    off    = (addr % 4) - ((addr % 4) % nbytes);
    full   = 64'd1 << nbits;
    field  = (64'(rd) >> (8 * off)) % full;
    if (!uns && field >= (full / 2)) field = field + (64'd1 << 32) - full;
    return field[31:0];
  endfunction

  typedef struct {
    string       name;
    bit          is64;
    logic [1:0]  size;
    bit          uns;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [63:0] exp;
  } ext_vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  ext_vec_t   vecs[13];
  logic [63:0] g32, g64;
  logic [31:0] alu_ops[5];
  exp_t        sb[$];

  initial begin
    vecs[0]  = '{"lb_off3",      0, 2'd0, 0, 64'h1003, 64'h80FF7F01, 64'hFFFFFF80};
    vecs[1]  = '{"lbu_off3",     0, 2'd0, 1, 64'h1003, 64'h80FF7F01, 64'h00000080};
    vecs[2]  = '{"lh_off2",      0, 2'd1, 0, 64'h1002, 64'h80FF7F01, 64'hFFFF80FF};
    vecs[3]  = '{"lhu_off0",     0, 2'd1, 1, 64'h1000, 64'h80FF7F01, 64'h00007F01};
    vecs[4]  = '{"lb_off1",      0, 2'd0, 0, 64'h1001, 64'h80FF7F01, 64'h0000007F};
    vecs[5]  = '{"lw",           0, 2'd2, 0, 64'h1000, 64'h80FF7F01, 64'h80FF7F01};
    vecs[6]  = '{"lh_masked",    0, 2'd1, 0, 64'h1003, 64'h80FF7F01, 64'hFFFF80FF};
    vecs[7]  = '{"lbu_off2",     0, 2'd0, 1, 64'h1002, 64'h80FF7F01, 64'h000000FF};
    vecs[8]  = '{"ld64_w_off4",  1, 2'd2, 0, 64'h1004, 64'h8000000100000000, 64'hFFFFFFFF80000001};
    vecs[9]  = '{"ld64_wu_off4", 1, 2'd2, 1, 64'h1004, 64'h8000000100000000, 64'h0000000080000001};
    vecs[10] = '{"ld64_d",       1, 2'd3, 0, 64'h1000, 64'h8000000100000000, 64'h8000000100000000};
    vecs[11] = '{"ld64_b_off7",  1, 2'd0, 0, 64'h1007, 64'h8000000100000000, 64'hFFFFFFFFFFFFFF80};
    vecs[12] = '{"ld64_hu_off6", 1, 2'd1, 1, 64'h1006, 64'h8000000100000000, 64'h0000000000008000};
    alu_ops  = '{32'h0000_0011, 32'hFFFF_FFFE, 32'h1234_5678, 32'h8000_0000, 32'h0F0F_0F0F};

    rst = 1'b0; allowout = 1'b1; validin = 1'b0; flush = 1'b0;
    input_pc = '0; input_rf_waddr = '0; input_rf_we = 1'b0; input_mem_read = 1'b0;
    input_mem_size = 2'd0; input_mem_unsigned = 1'b0; alu32 = '0; alu64 = '0;
    data_ok = 1'b0; rdata32 = '0; rdata64 = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_validout", validout, 0);
    check("rst_allowin",  allowin, 1);
    check("rst_pc",       out_pc, 0);
    check("rst_wdata",    wdata32, 0);
    check("rst_rf_we",    rf_we, 0);
    check("rst_waddr",    rf_waddr, 0);
    check("rst_fwd",      fwd_valid, 0);
    rst = 1'b1;
    cyc();

    // Reset while waiting: outputs clear at once and the late response is dropped.
    offer(1'b1, 2'd2, 1'b0, 64'h1000, 32'h0000_0ABC, 1'b1, 5'd7);
    cyc();
    validin = 1'b0;
    @(negedge clk);
    check("rmw_pc_held", out_pc, 32'h0000_0ABC);
    check("rmw_we_held", rf_we, 1);
    #1 rst = 1'b0;
    #1;
    check("rmw_pc_clr",   out_pc, 0);
    check("rmw_we_clr",   rf_we, 0);
    check("rmw_allowin",  allowin, 1);
    check("rmw_validout", validout, 0);
    #1 rst = 1'b1;
    cyc();
    respond(64'h5555_AAAA);
    @(negedge clk);
    check("rmw_late_vo", validout, 0);
    cyc();
    scramble_bus();
    offer(1'b0, 2'd0, 1'b0, 64'h77, 32'h0000_0B00, 1'b1, 5'd2);
    @(negedge clk);
    check("rmw_idle_allowin", allowin, 1);
    check("rmw_idle_wdata",   wdata32, 0);
    cyc();
    validin = 1'b0;
    @(negedge clk);
    check("rmw_next_vo",    validout, 1);
    check("rmw_next_wdata", wdata32, 32'h77);
    cyc();

    // Latency: three empty wait cycles, then the response.
    offer(1'b1, 2'd2, 1'b0, 64'h1000, 32'h0000_1100, 1'b1, 5'd4);
    cyc();
    validin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat3_wait_vo", validout, 0);
      check("lat3_wait_ai", allowin, 0);
      cyc();
    end
    respond(64'hDEAD_BEEF);
    @(negedge clk);
    check("lat3_dok_vo", validout, 0);
    cyc();
    scramble_bus();
    @(negedge clk);
    check("lat3_vo",    validout, 1);
    check("lat3_wdata", wdata32, 32'hDEAD_BEEF);
    check("lat3_fwd",   fwd_valid, 1);
    cyc();
    @(negedge clk);
    check("lat3_popped", validout, 0);

    // Zero-wait response.
    cyc();
    offer(1'b1, 2'd2, 1'b0, 64'h1000, 32'h0000_1104, 1'b1, 5'd4);
    cyc();
    validin = 1'b0;
    respond(64'h0BAD_F00D);
    @(negedge clk);
    check("lat0_entry_vo", validout, 0);
    check("lat0_fwd_wait", fwd_valid, 0);
    cyc();
    scramble_bus();
    @(negedge clk);
    check("lat0_vo",    validout, 1);
    check("lat0_wdata", wdata32, 32'h0BAD_F00D);
    cyc();

    // Backpressure: response buffered while WB stalls and the bus changes.
    offer(1'b1, 2'd2, 1'b0, 64'h1000, 32'h0000_1200, 1'b1, 5'd5);
    cyc();
    validin  = 1'b0;
    allowout = 1'b0;
    respond(64'hDEAD_BEEF);
    cyc();
    data_ok = 1'b0;
    rdata32 = 32'h1234_5678;
    rdata64 = 64'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_vo",    validout, 1);
      check("bp_wdata", wdata32, 32'hDEAD_BEEF);
      check("bp_ai",    allowin, 0);
      cyc();
    end
    allowout = 1'b1;
    @(negedge clk);
    check("bp_release_ai",    allowin, 1);
    check("bp_release_wdata", wdata32, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    check("bp_popped", validout, 0);
    cyc();

    // Flush in WAIT: the orphaned response is absorbed, and the refresh offered
    // on the flush edge is ignored.
    offer(1'b1, 2'd2, 1'b0, 64'h1000, 32'h0000_1300, 1'b1, 5'd6);
    cyc();
    offer(1'b0, 2'd0, 1'b0, 64'h99, 32'h0000_1304, 1'b1, 5'd8);
    flush = 1'b1;
    @(negedge clk);
    check("fl_vo",      validout, 0);
    check("fl_allowin", allowin, 1);
    cyc();
    flush   = 1'b0;
    validin = 1'b0;
    @(negedge clk);
    check("fl_disc_ai", allowin, 0);
    check("fl_disc_vo", validout, 0);
    check("fl_disc_we", rf_we, 0);
    check("fl_disc_pc", out_pc, 32'h0000_1300);
    cyc();
    respond(64'hBAD0_BAD0);
    @(negedge clk);
    check("fl_dok_vo", validout, 0);
    cyc();
    scramble_bus();
    @(negedge clk);
    check("fl_after_ai", allowin, 1);
    check("fl_after_vo", validout, 0);
    cyc();
    run_load(2'd2, 1'b0, 64'h1000, 64'h1111_2222, 1, g32, g64);
    check("fl_next_wdata", g32, 64'h1111_2222);

    // Extension table, covering both data widths.
    foreach (vecs[i]) begin
      run_load(vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].rdata, i % 3, g32, g64);
      check(vecs[i].name, vecs[i].is64 ? g64 : g32, vecs[i].exp);
    end

    // Back-to-back non-load ops, one per cycle.
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) offer(1'b0, 2'd0, 1'b0, 64'(alu_ops[k]), 32'h0000_4000 + 32'(4 * k), 1'b1, 5'd9);
      else       validin = 1'b0;
      @(negedge clk);
      if (k > 0) begin
        check("b2b_vo",    validout, 1);
        check("b2b_fwd",   fwd_valid, 1);
        check("b2b_ai",    allowin, 1);
        check("b2b_wdata", wdata32, alu_ops[k-1]);
      end
      cyc();
    end

    // Randomized traffic against the scoreboard model.
    begin
      int          n_rand;
      int          accepted;
      int          popped;
      int          cycles;
      bit          have_offer;
      bit          pending;
      int          pend_cnt;
      logic [31:0] pend_data;
      logic [31:0] offer_rd;
      int          offer_lat;
      exp_t        e;
      exp_t        got;
      n_rand = 200; accepted = 0; popped = 0; cycles = 0;
      have_offer = 0; pending = 0; pend_cnt = 0; pend_data = '0;
      offer_rd = '0; offer_lat = 0;
      validin = 1'b0;
      while (popped < n_rand && cycles < 5000) begin
        if (!have_offer && accepted < n_rand && $urandom_range(0, 3) != 0) begin
          logic        ld;
          logic [1:0]  sz;
          logic        un;
          logic [31:0] a;
          ld = 1'($urandom_range(0, 1));
          sz = 2'($urandom_range(0, 2));
          un = 1'($urandom_range(0, 1));
          a  = $urandom;
          offer(ld, sz, un, 64'(a), $urandom, 1'($urandom_range(0, 1)), 5'($urandom));
          offer_rd  = $urandom;
          offer_lat = $urandom_range(0, 3);
          e.pc    = input_pc;
          e.we    = input_rf_we;
          e.wdata = ld ? ref_load(int'(sz), un, a, offer_rd) : a;
          have_offer = 1;
        end
        validin  = have_offer;
        allowout = ($urandom_range(0, 3) != 0);
        scramble_bus();
        if (pending) begin
          if (pend_cnt == 0) begin
            respond(64'(pend_data));
            pending = 0;
          end else begin
            pend_cnt--;
          end
        end
        @(negedge clk);
        if (validout && allowout) begin
          if (sb.size() == 0) begin
            check("rnd_unexpected_pop", 1, 0);
          end else begin
            got = sb.pop_front();
            check("rnd_wdata", wdata32, got.wdata);
            check("rnd_pc",    out_pc, got.pc);
            check("rnd_we",    rf_we, got.we);
            check("rnd_fwd",   fwd_valid, got.we);
          end
          popped++;
        end
        if (validin && allowin) begin
          sb.push_back(e);
          accepted++;
          have_offer = 0;
          if (input_mem_read) begin
            pending   = 1;
            pend_cnt  = offer_lat;
            pend_data = offer_rd;
          end
        end
        cycles++;
        cyc();
      end
      validin  = 1'b0;
      allowout = 1'b1;
      scramble_bus();
      check("rnd_all_popped", 64'(popped), 64'(n_rand));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
Parametrised successor MEM stage. It sits between the EX and WB stages and keeps the same valid/allowin pipeline handshake.
- Adds a variable-latency data-SRAM response path: the stage stalls until data_ok arrives and buffers the response when WB is not accepting.
- Adds sub-word load extraction with sign or zero extension.
- Adds a pipeline flush that cancels the in-stage instruction and absorbs its orphaned response.

Parameters:
DATA_WIDTH, 32, datapath, register and SRAM data width; legal values 32 or 64.
OFF_W, $clog2(DATA_WIDTH/8), byte-offset bits of the address; derived, not overridden.
RF_ADDR_W, 5, register-file address width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
allowout  in  1  WB can accept.
validin  in  1  EX offers an instruction.
allowin  out  1  stage can accept from EX.
validout  out  1  stage offers a completed instruction to WB.
flush  in  1  kill the instruction in this stage (exception or ertn from a later stage).
input_pc  in  32  pc of the incoming instruction.
output_pc  out  32  held pc.
input_rf_waddr  in  RF_ADDR_W  destination register.
input_rf_we  in  1  register write enable.
output_rf_waddr  out  RF_ADDR_W  held destination register.
output_rf_we  out  1  held write enable, gated by valid.
input_mem_read  in  1  instruction is a load whose request EX has already handshaken.
input_mem_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_WIDTH=64).
input_mem_unsigned  in  1  zero-extend instead of sign-extend.
input_alu_result  in  DATA_WIDTH  load address, or result for non-loads.
data_sram_data_ok  in  1  read response valid this cycle.
data_sram_rdata  in  DATA_WIDTH  response data, aligned to the SRAM word.
output_rf_wdata  out  DATA_WIDTH  write-back data.
output_fwd_valid  out  1  output_rf_wdata is final and may be forwarded to ID.

Behaviour:
Reset:
- All registers clear on rst low, regardless of clk; a reset mid-wait drops any pending response.
- After reset: valid=0, state=IDLE, all held data 0.
- Outputs after reset: validout=0, allowin=1, output_* = 0, output_fwd_valid=0.

Handshake:
- readygo = !(valid && mem_read && state!=DONE).
- allowin = !valid || (readygo && allowout).
- validout = valid && readygo && !flush.
- Refresh (validin && allowin): latch all inputs and set valid=1.
- Pop without refresh: valid=0.

State machine, for loads only:
- IDLE -> WAIT on refresh with input_mem_read=1.
- WAIT -> DONE on data_ok; rdata is latched into rbuf on the same edge. data_ok during WAIT therefore yields readygo in the following cycle (one-cycle buffered response).
- DONE -> IDLE, or -> WAIT if a new load refreshes, on pop.
- Non-loads stay in IDLE; readygo=1.

Flush:
- Flush clears valid on the next edge. allowin=1 during flush, but the same-edge refresh is ignored: EX is flushed too.
- Flush while in WAIT -> DISCARD.
- DISCARD: allowin=0 until data_ok, then -> IDLE and the data is dropped.
- Flush in DONE or IDLE -> IDLE.
- data_ok in any state other than WAIT or DISCARD is a protocol error; assertion in simulation only.

Extraction (combinational from rbuf and the held address):
- off = addr[OFF_W-1:0], with the low bits masked to size alignment (misalignment is checked upstream).
- field = rbuf >> (8*off), truncated to 8, 16, 32 or 64 bits by size.
- Extended to DATA_WIDTH with the sign bit, or with zeros when unsigned.
- Word load at DATA_WIDTH=32 passes rbuf unchanged.

Write-back and forwarding:
- output_rf_wdata = mem_read ? extracted : alu_result.
- output_rf_we = valid && rf_we.
- output_fwd_valid = valid && rf_we && readygo.

Test Plan:
1. Reset mid-wait: load in WAIT, rst pulsed low between edges -> outputs clear immediately; a later data_ok is ignored and state=IDLE.
2. Latency: ld.w at addr 0x1000; data_ok after 3 cycles with rdata 0xDEADBEEF -> validout rises the next cycle, wdata=0xDEADBEEF. Same case with a 0-wait response -> validout one cycle after entry.
3. Backpressure: data_ok arrives while allowout=0 for 4 cycles, SRAM rdata then changes -> wdata stays 0xDEADBEEF (buffered) and allowin stays 0 until the pop.
4. Extension, rdata 0x80FF7F01:
   - ld.b at off 3 -> 0xFFFFFF80; ld.bu at off 3 -> 0x00000080.
   - ld.h at off 2 -> 0xFFFF80FF; ld.hu at off 0 -> 0x00007F01.
   - DATA_WIDTH=64 ld.w at off 4 of 0x8000000100000000 -> 0xFFFFFFFF80000001.
5. Flush in WAIT, data_ok 2 cycles later -> validout stays 0 throughout, allowin=0 until data_ok, then 1; the next load completes with its own data.
6. Back-to-back non-load ALU ops with allowout=1 -> one per cycle, validout continuous, output_fwd_valid=1 each cycle, wdata equals the alu_result of each op.
